mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_controller.sv | 235 +++++++++++++++++++++++
 tb/tb_mc_controller.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_controller.sv
// Multi-cycle RV32I(M) control FSM: fetch/decode/execute/memory/writeback
// sequencing with an ack-wait timeout, sticky trap and retire counter.
module mc_controller #(
  parameter int SUPPORT_M      = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  input  logic        imem_ack_i,
  input  logic [31:0] inst_i,
  input  logic        dmem_ack_i,
  input  logic        md_done_i,
  input  logic        br_eq_i,
  input  logic        br_lt_i,
  input  logic        br_ge_i,
  output logic [31:0] ir_o,
  output logic        pc_we_o,
  output logic        pc_sel_o,
  output logic        reg_we_o,
  output logic        a_sel_o,
  output logic        b_sel_o,
  output logic        mem_re_o,
  output logic        mem_we_o,
  output logic        br_un_o,
  output logic [1:0]  wb_sel_o,
  output logic [2:0]  imm_sel_o,
  output logic [3:0]  alu_sel_o,
  output logic        md_start_o,
  output logic [2:0]  md_sel_o,
  output logic        illegal_o,
  output logic        timeout_o,
  output logic [2:0]  state_o,
  output logic        retire_o,
  output logic [31:0] instret_o
);

  typedef enum logic [2:0] {
    FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
    WB = 3'd4, MDWAIT = 3'd5, TRAP = 3'd6
  } state_t;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LD = 7'b0000011,
                         OP_ST = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

  localparam logic [3:0] ALU_AND = 4'b0000, ALU_OR = 4'b0001, ALU_ADD = 4'b0010,
                         ALU_SUB = 4'b0011, ALU_SLT = 4'b0100, ALU_SL12 = 4'b0110,
                         ALU_XOR = 4'b0111, ALU_SLL = 4'b1000, ALU_SRL = 4'b1001,
                         ALU_AUIPC = 4'b1010, ALU_SLTU = 4'b1011, ALU_SRA = 4'b1100,
                         ALU_NOP = 4'b1111;

  localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] WAIT_LIMIT = 32'(TIMEOUT_CYCLES - 1);
  localparam bit          M_EN       = (SUPPORT_M != 0);

  state_t      state, state_d;
  logic [31:0] wait_cnt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic        is_load, is_store, is_branch, is_jump, is_m;
  logic        illegal_inst, taken, limit_hit;

  assign opcode    = ir_o[6:0];
  assign funct3    = ir_o[14:12];
  assign funct7    = ir_o[31:25];
  assign is_load   = (opcode == OP_LD);
  assign is_store  = (opcode == OP_ST);
  assign is_branch = (opcode == OP_BR);
  assign is_jump   = (opcode == OP_JAL) || (opcode == OP_JALR);
  assign is_m      = M_EN && (opcode == OP_REG) && (funct7 == 7'b0000001);
  assign limit_hit = TIMEOUT_EN && (wait_cnt == WAIT_LIMIT);
  assign state_o   = state;

  // Legality check over the latched instruction word.
  always_comb begin
    illegal_inst = 1'b0;
    unique case (opcode)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: illegal_inst = 1'b0;
      OP_BR:  illegal_inst = (funct3 == 3'b010) || (funct3 == 3'b011);
      OP_LD:  illegal_inst = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      OP_ST:  illegal_inst = (funct3 > 3'b010);
      OP_IMM: begin
        if (funct3 == 3'b001)
          illegal_inst = (funct7 != 7'b0000000);
        else if (funct3 == 3'b101)
          illegal_inst = (funct7 != 7'b0000000) && (funct7 != 7'b0100000);
      end
      OP_REG: illegal_inst = !((funct7 == 7'b0000000) ||
                               ((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101))) ||
                               (M_EN && (funct7 == 7'b0000001)));
      default: illegal_inst = 1'b1;
    endcase
  end

  always_comb begin
    unique case (funct3)
      3'b000:  taken = br_eq_i;
      3'b001:  taken = !br_eq_i;
      3'b100:  taken = br_lt_i;
      3'b101:  taken = br_ge_i;
      3'b110:  taken = br_lt_i;
      3'b111:  taken = !br_lt_i;
      default: taken = 1'b0;
    endcase
  end

  // Static datapath selects depend only on the latched instruction.
  always_comb begin
    alu_sel_o = ALU_NOP;
    imm_sel_o = 3'b111;
    wb_sel_o  = 2'b01;
    a_sel_o   = is_branch || (opcode == OP_JAL) || (opcode == OP_AUIPC);
    b_sel_o   = (opcode != OP_REG);
    br_un_o   = is_branch && funct3[1];
    md_sel_o  = is_m ? funct3 : 3'b000;
    unique case (opcode)
      OP_REG, OP_IMM: begin
        imm_sel_o = (opcode == OP_IMM) ? 3'b000 : 3'b111;
        wb_sel_o  = is_m ? 2'b11 : 2'b01;
        if (!is_m) begin
          unique case (funct3)
            3'b000:  alu_sel_o = (opcode == OP_REG && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_sel_o = ALU_SLL;
            3'b010:  alu_sel_o = ALU_SLT;
            3'b011:  alu_sel_o = ALU_SLTU;
            3'b100:  alu_sel_o = ALU_XOR;
            3'b101:  alu_sel_o = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  alu_sel_o = ALU_OR;
            default: alu_sel_o = ALU_AND;
          endcase
        end
      end
      OP_LUI:   begin alu_sel_o = ALU_SL12;  imm_sel_o = 3'b011; end
      OP_AUIPC: begin alu_sel_o = ALU_AUIPC; imm_sel_o = 3'b011; end
      OP_JAL:   begin alu_sel_o = ALU_ADD;   imm_sel_o = 3'b001; wb_sel_o = 2'b10; end
      OP_JALR:  begin alu_sel_o = ALU_ADD;   imm_sel_o = 3'b000; wb_sel_o = 2'b10; end
      OP_BR:    begin alu_sel_o = ALU_ADD;   imm_sel_o = 3'b100; end
      OP_LD:    begin alu_sel_o = ALU_ADD;   imm_sel_o = 3'b000; wb_sel_o = 2'b00; end
      OP_ST:    begin alu_sel_o = ALU_ADD;   imm_sel_o = 3'b010; end
      default: ;
    endcase
  end

  // Next-state and strobes; an ack always takes priority over the timeout.
  always_comb begin
    state_d    = state;
    imem_req_o = 1'b0;
    pc_we_o    = 1'b0;
    pc_sel_o   = 1'b0;
    reg_we_o   = 1'b0;
    mem_re_o   = 1'b0;
    mem_we_o   = 1'b0;
    md_start_o = 1'b0;
    unique case (state)
      FETCH: begin
        imem_req_o = 1'b1;
        if (imem_ack_i)     state_d = DECODE;
        else if (limit_hit) state_d = TRAP;
      end
      DECODE: state_d = illegal_inst ? TRAP : EXEC;
      EXEC: begin
        if (is_branch) begin
          pc_we_o  = 1'b1;
          pc_sel_o = taken;
          state_d  = FETCH;
        end else if (is_load || is_store) begin
          state_d = MEM;
        end else if (is_m) begin
          md_start_o = 1'b1;
          state_d    = MDWAIT;
        end else begin
          state_d = WB;
        end
      end
      MEM: begin
        mem_re_o = is_load;
        mem_we_o = is_store;
        if (dmem_ack_i) begin
          if (is_load) state_d = WB;
          else begin
            pc_we_o = 1'b1;
            state_d = FETCH;
          end
        end else if (limit_hit) begin
          state_d = TRAP;
        end
      end
      MDWAIT: if (md_done_i) state_d = WB;
      WB: begin
        reg_we_o = (ir_o[11:7] != 5'd0);
        pc_we_o  = 1'b1;
        pc_sel_o = is_jump;
        state_d  = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
    retire_o = (state_d == FETCH) && (state inside {EXEC, MEM, WB});
    if (rst_i) begin
      imem_req_o = 1'b0;
      pc_we_o    = 1'b0;
      reg_we_o   = 1'b0;
      mem_re_o   = 1'b0;
      mem_we_o   = 1'b0;
      md_start_o = 1'b0;
      retire_o   = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= FETCH;
    else       state <= state_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ir_o      <= 32'h0000_0013;
      instret_o <= 32'd0;
      wait_cnt  <= 32'd0;
      illegal_o <= 1'b0;
      timeout_o <= 1'b0;
    end else begin
      if (state == FETCH && imem_ack_i) ir_o <= inst_i;
      if (retire_o) instret_o <= instret_o + 32'd1;
      if ((state_d != state) && (state_d == FETCH || state_d == MEM))
        wait_cnt <= 32'd0;
      else if ((state == FETCH && !imem_ack_i) || (state == MEM && !dmem_ack_i))
        wait_cnt <= wait_cnt + 32'd1;
      if (state == DECODE && illegal_inst) illegal_o <= 1'b1;
      if ((state == FETCH || state == MEM) && state_d == TRAP) timeout_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed scenarios plus random instruction words,
// judged against a mask/match encoding table and a protocol walk.
module tb_mc_controller;

  localparam int K_OP = 0, K_OPI = 1, K_LUI = 2, K_AUIPC = 3, K_JAL = 4, K_JALR = 5,
                 K_BR = 6, K_LD = 7, K_ST = 8, K_M = 9, K_ILL = 10;

  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    int          kind;
    logic [3:0]  alu;
  } pat_t;

  pat_t pats[$];

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic imem_ack_i = 1'b0, dmem_ack_i = 1'b0, md_done_i = 1'b0;
  logic br_eq_i = 1'b0, br_lt_i = 1'b0, br_ge_i = 1'b0;
  logic [31:0] inst_i = 32'd0;

  logic        imem_req_o, pc_we_o, pc_sel_o, reg_we_o, a_sel_o, b_sel_o;
  logic        mem_re_o, mem_we_o, br_un_o, md_start_o, illegal_o, timeout_o, retire_o;
  logic [1:0]  wb_sel_o;
  logic [2:0]  imm_sel_o, md_sel_o, state_o;
  logic [3:0]  alu_sel_o;
  logic [31:0] ir_o, instret_o;

  logic        n_imem_req, n_pc_we, n_pc_sel, n_reg_we, n_a_sel, n_b_sel;
  logic        n_mem_re, n_mem_we, n_br_un, n_md_start, n_illegal, n_timeout, n_retire;
  logic [1:0]  n_wb_sel;
  logic [2:0]  n_imm_sel, n_md_sel, n_state;
  logic [3:0]  n_alu_sel;
  logic [31:0] n_ir, n_instret;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_instret = 32'd0;

  always #5 clk_i = ~clk_i;

  mc_controller #(.SUPPORT_M(1), .TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .imem_req_o(imem_req_o), .imem_ack_i(imem_ack_i),
    .inst_i(inst_i), .dmem_ack_i(dmem_ack_i), .md_done_i(md_done_i),
    .br_eq_i(br_eq_i), .br_lt_i(br_lt_i), .br_ge_i(br_ge_i), .ir_o(ir_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .reg_we_o(reg_we_o), .a_sel_o(a_sel_o),
    .b_sel_o(b_sel_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o), .br_un_o(br_un_o),
    .wb_sel_o(wb_sel_o), .imm_sel_o(imm_sel_o), .alu_sel_o(alu_sel_o),
    .md_start_o(md_start_o), .md_sel_o(md_sel_o), .illegal_o(illegal_o),
    .timeout_o(timeout_o), .state_o(state_o), .retire_o(retire_o), .instret_o(instret_o)
  );

  mc_controller #(.SUPPORT_M(0), .TIMEOUT_CYCLES(255)) dut_n (
    .clk_i(clk_i), .rst_i(rst_i), .imem_req_o(n_imem_req), .imem_ack_i(imem_ack_i),
    .inst_i(inst_i), .dmem_ack_i(dmem_ack_i), .md_done_i(md_done_i),
    .br_eq_i(br_eq_i), .br_lt_i(br_lt_i), .br_ge_i(br_ge_i), .ir_o(n_ir),
    .pc_we_o(n_pc_we), .pc_sel_o(n_pc_sel), .reg_we_o(n_reg_we), .a_sel_o(n_a_sel),
    .b_sel_o(n_b_sel), .mem_re_o(n_mem_re), .mem_we_o(n_mem_we), .br_un_o(n_br_un),
    .wb_sel_o(n_wb_sel), .imm_sel_o(n_imm_sel), .alu_sel_o(n_alu_sel),
    .md_start_o(n_md_start), .md_sel_o(n_md_sel), .illegal_o(n_illegal),
    .timeout_o(n_timeout), .state_o(n_state), .retire_o(n_retire), .instret_o(n_instret)
  );

  function automatic void addPat(input logic [31:0] mask, input logic [31:0] match,
                                 input int kind, input logic [3:0] alu);
    pat_t p;
    p.mask = mask; p.match = match; p.kind = kind; p.alu = alu;
    pats.push_back(p);
  endfunction

  // Every legal RV32IM encoding as a mask/match pair with its ALU operation.
  task automatic buildTable();
    logic [3:0] alu_f3 [8] = '{4'd2, 4'd8, 4'd4, 4'd11, 4'd7, 4'd9, 4'd1, 4'd0};
    addPat(32'h7F, 32'h37, K_LUI, 4'd6);
    addPat(32'h7F, 32'h17, K_AUIPC, 4'd10);
    addPat(32'h7F, 32'h6F, K_JAL, 4'd2);
    addPat(32'h7F, 32'h67, K_JALR, 4'd2);
    for (int f = 0; f < 8; f++) begin
      if (f != 2 && f != 3) addPat(32'h707F, 32'h63 | (32'(f) << 12), K_BR, 4'd2);
      if (f != 3 && f < 6)  addPat(32'h707F, 32'h03 | (32'(f) << 12), K_LD, 4'd2);
      if (f < 3)            addPat(32'h707F, 32'h23 | (32'(f) << 12), K_ST, 4'd2);
      if (f != 1 && f != 5) addPat(32'h707F, 32'h13 | (32'(f) << 12), K_OPI, alu_f3[f]);
      addPat(32'hFE00707F, 32'h33 | (32'(f) << 12), K_OP, alu_f3[f]);
      addPat(32'hFE00707F, 32'h02000033 | (32'(f) << 12), K_M, 4'd15);
    end
    addPat(32'hFE00707F, 32'h00001013, K_OPI, 4'd8);
    addPat(32'hFE00707F, 32'h00005013, K_OPI, 4'd9);
    addPat(32'hFE00707F, 32'h40005013, K_OPI, 4'd12);
    addPat(32'hFE00707F, 32'h40000033, K_OP, 4'd3);
    addPat(32'hFE00707F, 32'h40005033, K_OP, 4'd12);
  endtask

  function automatic int findPat(input logic [31:0] w);
    for (int i = 0; i < pats.size(); i++)
      if ((w & pats[i].mask) == pats[i].match) return i;
    return -1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic fack, input logic [31:0] w, input logic dack,
                               input logic mdone, input logic eq, input logic lt, input logic ge);
    imem_ack_i = fack; inst_i = w; dmem_ack_i = dack; md_done_i = mdone;
    br_eq_i = eq; br_lt_i = lt; br_ge_i = ge;
    @(negedge clk_i);
  endtask

  task automatic nextCycle();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [6:0] strobes();
    return {imem_req_o, pc_we_o, reg_we_o, mem_re_o, mem_we_o, md_start_o, retire_o};
  endfunction

  task automatic doReset();
    rst_i = 1'b1;
    #2;
    checkOutput("rst_state", state_o, 0);
    checkOutput("rst_ir", ir_o, 32'h13);
    checkOutput("rst_instret", instret_o, 0);
    checkOutput("rst_flags", {illegal_o, timeout_o}, 0);
    checkOutput("rst_strobes", strobes(), 0);
    checkOutput("rst_n_state", n_state, 0);
    exp_instret = 32'd0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
  endtask

  // Walks one instruction through the expected state sequence; starts and ends in FETCH.
  task automatic runInstr(input logic [31:0] w, input int fdly, input int mdly, input int mddly,
                          input logic eq, input logic lt, input logic ge);
    int idx, kind;
    logic taken;
    logic [2:0] f3;
    logic [1:0] wb;
    logic [2:0] imm;
    idx  = findPat(w);
    kind = (idx < 0) ? K_ILL : pats[idx].kind;
    f3   = w[14:12];
    for (int k = 0; k <= fdly; k++) begin
      applyStimulus(k == fdly, (k == fdly) ? w : $urandom, 0, 0, eq, lt, ge);
      checkOutput("fetch_state", state_o, 0);
      checkOutput("fetch_req", imem_req_o, 1);
      if (k == 0) checkOutput("instret", instret_o, exp_instret);
      nextCycle();
    end
    applyStimulus(0, $urandom, 0, 0, eq, lt, ge);
    checkOutput("decode_state", state_o, 1);
    checkOutput("decode_ir", ir_o, w);
    checkOutput("decode_strobes", strobes(), 0);
    nextCycle();
    if (kind == K_ILL) begin
      applyStimulus(0, $urandom, 1, 1, eq, lt, ge);
      checkOutput("trap_state", state_o, 6);
      checkOutput("trap_flags", {illegal_o, timeout_o}, 2'b10);
      checkOutput("trap_strobes", strobes(), 0);
      nextCycle();
      applyStimulus(1, $urandom, 1, 1, eq, lt, ge);
      checkOutput("trap_sticky", state_o, 6);
      nextCycle();
      doReset();
      return;
    end
    case (kind)
      K_OPI, K_LD, K_JALR: imm = 3'b000;
      K_JAL:               imm = 3'b001;
      K_ST:                imm = 3'b010;
      K_LUI, K_AUIPC:      imm = 3'b011;
      K_BR:                imm = 3'b100;
      default:             imm = 3'b111;
    endcase
    taken = (f3 == 0 && eq) || (f3 == 1 && !eq) || (f3 == 4 && lt) ||
            (f3 == 5 && ge) || (f3 == 6 && lt) || (f3 == 7 && !lt);
    applyStimulus(0, $urandom, 0, kind == K_M, eq, lt, ge);
    checkOutput("exec_state", state_o, 2);
    checkOutput("exec_alu", alu_sel_o, pats[idx].alu);
    checkOutput("exec_imm", imm_sel_o, imm);
    checkOutput("exec_asel", a_sel_o, kind == K_BR || kind == K_JAL || kind == K_AUIPC);
    checkOutput("exec_bsel", b_sel_o, !(kind == K_OP || kind == K_M));
    checkOutput("exec_mdstart", md_start_o, kind == K_M);
    if (kind == K_M) checkOutput("exec_mdsel", md_sel_o, f3);
    if (kind == K_BR) begin
      checkOutput("br_pcwe", pc_we_o, 1);
      checkOutput("br_pcsel", pc_sel_o, taken);
      checkOutput("br_un", br_un_o, f3 >= 6);
      checkOutput("br_regwe", reg_we_o, 0);
      checkOutput("br_retire", retire_o, 1);
    end else begin
      checkOutput("exec_pcwe", pc_we_o, 0);
    end
    nextCycle();
    if (kind == K_BR) begin
      exp_instret++;
      return;
    end
    if (kind == K_LD || kind == K_ST) begin
      for (int k = 0; k <= mdly; k++) begin
        applyStimulus(0, $urandom, k == mdly, 0, eq, lt, ge);
        checkOutput("mem_state", state_o, 3);
        checkOutput("mem_re", mem_re_o, kind == K_LD);
        checkOutput("mem_we", mem_we_o, kind == K_ST);
        checkOutput("mem_pcwe", {pc_we_o, pc_sel_o, retire_o},
                    (kind == K_ST && k == mdly) ? 3'b101 : 3'b000);
        nextCycle();
      end
      if (kind == K_ST) begin
        exp_instret++;
        return;
      end
    end
    if (kind == K_M) begin
      for (int k = 0; k <= mddly; k++) begin
        applyStimulus(0, $urandom, 0, k == mddly, eq, lt, ge);
        checkOutput("mdwait_state", state_o, 5);
        checkOutput("mdwait_start", md_start_o, 0);
        nextCycle();
      end
    end
    case (kind)
      K_LD:         wb = 2'b00;
      K_JAL, K_JALR: wb = 2'b10;
      K_M:          wb = 2'b11;
      default:      wb = 2'b01;
    endcase
    applyStimulus(0, $urandom, 0, 0, eq, lt, ge);
    checkOutput("wb_state", state_o, 4);
    checkOutput("wb_sel", wb_sel_o, wb);
    checkOutput("wb_regwe", reg_we_o, w[11:7] != 0);
    checkOutput("wb_pc", {pc_we_o, pc_sel_o}, {1'b1, kind == K_JAL || kind == K_JALR});
    checkOutput("wb_retire", retire_o, 1);
    nextCycle();
    exp_instret++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired before end of test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w;
    buildTable();
    #1;
    doReset();

    // addi x1,x0,5 with immediate ack, then again acked on the last allowed cycle
    runInstr(32'h00500093, 0, 0, 0, 0, 0, 0);
    checkOutput("addi_instret", instret_o, 1);
    runInstr(32'h00500093, 3, 0, 0, 0, 0, 0);
    runInstr(32'h00000463, 0, 0, 0, 1, 0, 1);
    runInstr(32'h0000A103, 0, 2, 0, 0, 0, 0);

    doReset();
    runInstr(32'h022081B3, 1, 0, 2, 0, 0, 0);
    checkOutput("nom_state", n_state, 6);
    checkOutput("nom_illegal", n_illegal, 1);
    checkOutput("nom_pcwe", n_pc_we, 0);

    runInstr(32'hFFFFFFFF, 0, 0, 0, 0, 0, 0);

    // fetch with no ack times out after four cycles
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, $urandom, 0, 0, 0, 0, 0);
      checkOutput("to_fetch", state_o, 0);
      nextCycle();
    end
    applyStimulus(1, $urandom, 1, 1, 0, 0, 0);
    checkOutput("to_state", state_o, 6);
    checkOutput("to_flags", {illegal_o, timeout_o}, 2'b01);
    checkOutput("to_strobes", strobes(), 0);
    nextCycle();
    doReset();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) w = $urandom;
      else begin
        int p;
        p = $urandom_range(0, pats.size() - 1);
        w = ($urandom & ~pats[p].mask) | pats[p].match;
      end
      runInstr(w, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 4),
               1'($urandom), 1'($urandom), 1'($urandom));
    end

    // asynchronous reset in the middle of a load's memory wait
    runInstr(32'h00500093, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 32'h0000A103, 0, 0, 0, 0, 0); nextCycle();
    applyStimulus(0, 32'd0, 0, 0, 0, 0, 0);        nextCycle();
    applyStimulus(0, 32'd0, 0, 0, 0, 0, 0);        nextCycle();
    applyStimulus(0, 32'd0, 0, 0, 0, 0, 0);
    checkOutput("pre_rst_mem", {state_o, mem_re_o}, {3'd3, 1'b1});
    checkOutput("pre_rst_instret", instret_o, exp_instret);
    #1;
    rst_i = 1'b1;
    #1;
    checkOutput("midrst_state", state_o, 0);
    checkOutput("midrst_memre", mem_re_o, 0);
    checkOutput("midrst_instret", instret_o, 0);
    exp_instret = 32'd0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    runInstr(32'h00500093, 0, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
